// File: rtl/mmio_host_bridge.sv
// Host-side MMIO master: turns one host register command into a single
// req_val/req_rdy transaction and captures the matching response.
module mmio_host_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_cmd,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_go,
  output logic              host_busy,
  output logic              host_done,
  output logic              host_err,
  output logic              host_timeout,
  output logic [DATA_W-1:0] host_rdata,
  output logic [CNT_W-1:0]  host_txn_cnt,
  output logic              req_cmd,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  output logic              req_val,
  input  logic              req_rdy,
  input  logic              resp_cmd,
  input  logic [ADDR_W-1:0] resp_addr,
  input  logic [DATA_W-1:0] resp_data,
  input  logic              resp_val,
  output logic              resp_rdy
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  txn_cnt_q, txn_cnt_d;
  logic              req_cmd_q, req_cmd_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic              req_val_q, req_val_d;
  logic              resp_rdy_q, resp_rdy_d;

  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    rdata_d    = rdata_q;
    txn_cnt_d  = txn_cnt_q;
    req_cmd_d  = req_cmd_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_val_d  = req_val_q;
    resp_rdy_d = resp_rdy_q;

    case (state_q)
      IDLE: begin
        if (host_go) begin
          req_cmd_d  = host_cmd;
          req_addr_d = host_addr;
          req_data_d = host_wdata;
          done_d     = 1'b0;
          err_d      = 1'b0;
          timeout_d  = 1'b0;
          busy_d     = 1'b1;
          req_val_d  = 1'b1;
          to_cnt_d   = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (req_val_q && req_rdy) begin
          req_val_d  = 1'b0;
          resp_rdy_d = 1'b1;
          state_d    = WAIT;
        end else if (to_cnt_q == TO_LAST) begin
          req_val_d  = 1'b0;
          busy_d     = 1'b0;
          timeout_d  = 1'b1;
          state_d    = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      WAIT: begin
        // A fired request is always answered, so this state has no timeout.
        if (resp_val) begin
          rdata_d    = resp_data;
          done_d     = 1'b1;
          txn_cnt_d  = txn_cnt_q + 1'b1;
          err_d      = (resp_cmd != req_cmd_q) || (resp_addr != req_addr_q);
          resp_rdy_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        req_val_d  = 1'b0;
        resp_rdy_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      to_cnt_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      rdata_q    <= '0;
      txn_cnt_q  <= '0;
      req_cmd_q  <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_val_q  <= 1'b0;
      resp_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      rdata_q    <= rdata_d;
      txn_cnt_q  <= txn_cnt_d;
      req_cmd_q  <= req_cmd_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_val_q  <= req_val_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

  assign host_busy    = busy_q;
  assign host_done    = done_q;
  assign host_err     = err_q;
  assign host_timeout = timeout_q;
  assign host_rdata   = rdata_q;
  assign host_txn_cnt = txn_cnt_q;
  assign req_cmd      = req_cmd_q;
  assign req_addr     = req_addr_q;
  assign req_data     = req_data_q;
  assign req_val      = req_val_q;
  assign resp_rdy     = resp_rdy_q;

endmodule
